// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared definitions for the two-requester ALU arbiter. This package holds
// the ALU opcode encodings and the arbiter FSM state encoding.
package alu_arbiter_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_alu_core.sv
// alu_core
// Combinational WIDTH-bit ALU used by alu_arbiter.
// Ports:
//   a_i, b_i   operands
//   ctrl_i     operation code (see alu_arbiter_pkg)
//   result_o   result, low WIDTH bits; 0 for unsupported codes
//   zero_o     result_o == 0
//   err_o      ctrl_i is not a supported code (011, 111)
module alu_core
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       ctrl_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             err_o
);

    always_comb begin
        result_o = '0;
        err_o    = 1'b0;
        case (ctrl_i)
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_MUL:  result_o = a_i * b_i;
            // Unsigned compare, zero-extended to the full width.
            OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            default: err_o    = 1'b1;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Arbitrates two requesters onto one shared ALU. Each operation takes
// accept (IDLE) -> EXEC (one cycle, result registered) -> RESP (held until
// the owner's rsp ready). Ties are broken by a round-robin pointer that is
// flipped to the loser on every acceptance.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   reqN_valid/ready, reqN_a/b/ctrl request handshake and operands, N=0,1
//   rspN_valid/ready                response handshake, N=0,1
//   rsp_result, rsp_zero, rsp_err   registered result shared by both ports
//
// state   | meaning
// IDLE    | waiting for a request; grant one valid requester
// EXEC    | latched operands drive the ALU; result is registered
// RESP    | rsp valid toward owner; outputs held until owner ready
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_ctrl,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err
);

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_err;
    logic             grant0;
    logic             grant1;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .a_i      (a_q),
        .b_i      (b_q),
        .ctrl_i   (ctrl_q),
        .result_o (alu_result),
        .zero_o   (alu_zero),
        .err_o    (alu_err)
    );

    // A lone valid requester always wins; the pointer only matters on a tie.
    assign grant0 = req0_valid && (!req1_valid || !ptr_q);
    assign grant1 = req1_valid && (!req0_valid ||  ptr_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        ctrl_d     = ctrl_q;
        result_d   = result_q;
        zero_d     = zero_q;
        err_d      = err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) begin
                    owner_d = grant1;
                    // Point at the requester that did not win.
                    ptr_d   = grant0;
                    a_d     = grant1 ? req1_a    : req0_a;
                    b_d     = grant1 ? req1_b    : req0_b;
                    ctrl_d  = grant1 ? req1_ctrl : req0_ctrl;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                err_d    = alu_err;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid =  owner_q;
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [2:0]  req0_ctrl;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [2:0]  req1_ctrl;
    logic        rsp0_valid, rsp0_ready;
    logic        rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_err;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ctrl  (req0_ctrl),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ctrl  (req1_ctrl),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    typedef struct {
        string       name;
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic issue(input bit who, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        if (who) begin
            req1_ctrl = c; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_ctrl = c; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
    endtask

    // Bounded wait for the grant of requester 'who'; returns just before the accept edge.
    task automatic wait_grant(input bit who, input string nm);
        int n = 0;
        #1;
        while (!(who ? req1_ready : req0_ready) && n < 20) begin
            tick();
            n++;
        end
        check({nm, " grant"}, {31'd0, (who ? req1_ready : req0_ready)}, 32'd1);
    endtask

    task automatic do_op(input bit who, input vec_t v);
        issue(who, v.ctrl, v.a, v.b);
        wait_grant(who, v.name);
        tick();                              // accept edge N
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({v.name, " exec no rsp"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        tick();                              // N+1: result registered, RESP
        check({v.name, " rsp valid"}, {30'd0, rsp1_valid, rsp0_valid}, who ? 32'd2 : 32'd1);
        check({v.name, " result"}, rsp_result, v.exp_res);
        check({v.name, " zero"}, {31'd0, rsp_zero}, {31'd0, v.exp_zero});
        check({v.name, " err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
        if (who) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check({v.name, " rsp done"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    endtask

    initial begin
        vec_t v;
        int   n;
        bit   g;

        vecs[0]  = '{"and",      3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0};
        vecs[1]  = '{"or",       3'b001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0};
        vecs[2]  = '{"add",      3'b010, 32'd7,         32'd5,         32'd12,        1'b0, 1'b0};
        vecs[3]  = '{"add_wrap", 3'b010, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0};
        vecs[4]  = '{"sub_neg",  3'b100, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[5]  = '{"sub_zero", 3'b100, 32'd9,         32'd9,         32'd0,         1'b1, 1'b0};
        vecs[6]  = '{"mul_wrap", 3'b101, 32'h0001_0000, 32'h0001_0000, 32'd0,         1'b1, 1'b0};
        vecs[7]  = '{"mul",      3'b101, 32'd6,         32'd7,         32'd42,        1'b0, 1'b0};
        vecs[8]  = '{"slt_t",    3'b110, 32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0};
        vecs[9]  = '{"slt_f",    3'b110, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0};
        vecs[10] = '{"op011",    3'b011, 32'd5,         32'd5,         32'd0,         1'b1, 1'b1};
        vecs[11] = '{"op111",    3'b111, 32'd5,         32'd5,         32'd0,         1'b1, 1'b1};

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("reset result", rsp_result, 32'd0);
        check("reset flags", {30'd0, rsp_zero, rsp_err}, 32'd0);
        check("reset valids", {28'd0, req1_ready, req0_ready, rsp1_valid, rsp0_valid}, 32'd0);

        // Single op, then the opcode table (requester 0 alone)
        v = '{"single", 3'b010, 32'd7, 32'd5, 32'd12, 1'b0, 1'b0};
        do_op(1'b0, v);
        for (int i = 0; i < 12; i++) do_op(1'b0, vecs[i]);
        do_op(1'b1, vecs[7]);

        // Backpressure on requester 1; non-owner rsp0_ready must be ignored
        issue(1'b1, 3'b101, 32'd6, 32'd7);
        wait_grant(1'b1, "bp");
        tick();
        req1_valid = 1'b0;
        issue(1'b0, 3'b010, 32'd1, 32'd1);
        rsp0_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp rsp1 held", {31'd0, rsp1_valid}, 32'd1);
            check("bp result held", rsp_result, 32'd42);
            check("bp ready low", {30'd0, req1_ready, req0_ready}, 32'd0);
            check("bp rsp0 low", {31'd0, rsp0_valid}, 32'd0);
            tick();
        end
        rsp1_ready = 1'b1;
        tick();
        check("bp released", {31'd0, rsp1_valid}, 32'd0);
        check("bp idle grant", {31'd0, req0_ready}, 32'd1);
        req0_valid = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        tick();

        // Contention after reset: grants alternate 0,1,0,1
        do_reset();
        issue(1'b0, 3'b100, 32'd9, 32'd9);
        issue(1'b1, 3'b010, 32'd3, 32'd3);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(req0_ready || req1_ready) && n < 20) begin
                tick();
                n++;
            end
            check("cont any grant", {31'd0, (req0_ready | req1_ready)}, 32'd1);
            check("cont one grant", {31'd0, (req0_ready & req1_ready)}, 32'd0);
            g = req1_ready;
            check("cont order", {31'd0, g}, (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            tick();
            check("cont rsp owner", {30'd0, rsp1_valid, rsp0_valid}, g ? 32'd2 : 32'd1);
            check("cont result", rsp_result, g ? 32'd6 : 32'd0);
            check("cont zero", {31'd0, rsp_zero}, g ? 32'd0 : 32'd1);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        tick();

        // Reset in RESP: pointer left at 1 by the accept, reset must clear it
        issue(1'b0, 3'b010, 32'd7, 32'd5);
        wait_grant(1'b0, "rst");
        tick();
        req0_valid = 1'b0;
        tick();
        check("rst pre rsp", {31'd0, rsp0_valid}, 32'd1);
        do_reset();
        check("rst no rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        check("rst result", rsp_result, 32'd0);
        tick();
        check("rst no rsp later", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst ptr grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Operand hold: inputs change right after accept
        issue(1'b0, 3'b010, 32'd7, 32'd5);
        wait_grant(1'b0, "hold");
        tick();
        req0_valid = 1'b0;
        req0_a = 32'd100;
        req0_b = 32'd100;
        tick();
        check("hold rsp", {31'd0, rsp0_valid}, 32'd1);
        check("hold result", rsp_result, 32'd12);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
